// File: rtl/oam_dma_pkg.sv
// Shared constants for the sprite DMA engine: bus addresses, R/W encoding and FSM state codes.
package oam_dma_pkg;

    localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
    localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
    localparam int          XFER_LEN      = 256;
    localparam logic [7:0]  LAST_IDX      = 8'(XFER_LEN - 1);

    // k6502 bus direction encoding
    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic [2:0] DMA_IDLE  = 3'd0;
    localparam logic [2:0] DMA_HALT  = 3'd1;
    localparam logic [2:0] DMA_ALIGN = 3'd2;
    localparam logic [2:0] DMA_READ  = 3'd3;
    localparam logic [2:0] DMA_WRITE = 3'd4;

endpackage

// File: rtl/oam_dma_if.sv
// Bus bundle between the k6502 core, the sprite DMA engine and the memory/PPU decode.
interface oam_dma_if;

    logic [15:0] cpu_a;
    logic [7:0]  cpu_d;
    logic        cpu_rw;
    logic        cpu_halt;
    logic [15:0] dma_a;
    logic [7:0]  dma_d_in;
    logic [7:0]  dma_d_out;
    logic        dma_rw;
    logic        dma_busy;

    modport master (
        input  cpu_a, cpu_d, cpu_rw, dma_d_in,
        output cpu_halt, dma_a, dma_d_out, dma_rw, dma_busy
    );

    modport slave (
        output cpu_a, cpu_d, cpu_rw, dma_d_in,
        input  cpu_halt, dma_a, dma_d_out, dma_rw, dma_busy
    );

endinterface

// File: rtl/oam_dma.sv
// Sprite DMA: snoops core writes to $4014, halts the core and copies one 256-byte page
// into the PPU OAM data port, one read/write pair per byte.
module oam_dma
    import oam_dma_pkg::*;
(
    input logic       clk,
    input logic       rst_n,
    oam_dma_if.master bus
);

    logic [2:0] state;
    logic [2:0] state_nxt;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data_buf;
    logic       odd;
    logic       trigger;

    // Only recognised in IDLE, so retriggers and the final WRITE edge are ignored.
    assign trigger = (state == DMA_IDLE) && (bus.cpu_rw == RW_WRITE) &&
                     (bus.cpu_a == DMA_REG_ADDR);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            DMA_IDLE:  if (trigger) state_nxt = DMA_HALT;
            DMA_HALT:  state_nxt = odd ? DMA_ALIGN : DMA_READ;
            DMA_ALIGN: state_nxt = DMA_READ;
            DMA_READ:  state_nxt = DMA_WRITE;
            DMA_WRITE: state_nxt = (idx == LAST_IDX) ? DMA_IDLE : DMA_READ;
            default:   state_nxt = DMA_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= DMA_IDLE;
            page     <= '0;
            idx      <= '0;
            data_buf <= '0;
            odd      <= 1'b0;
        end else begin
            odd   <= ~odd;
            state <= state_nxt;
            case (state)
                DMA_IDLE: begin
                    if (trigger) begin
                        page <= bus.cpu_d;
                        idx  <= '0;
                    end
                end
                DMA_READ:  data_buf <= bus.dma_d_in;
                // idx is 8 bits and never carries into page
                DMA_WRITE: if (idx != LAST_IDX) idx <= idx + 8'd1;
                default: ;
            endcase
        end
    end

    assign bus.cpu_halt  = (state != DMA_IDLE);
    assign bus.dma_busy  = bus.cpu_halt;
    assign bus.dma_rw    = (state == DMA_WRITE) ? RW_WRITE : RW_READ;
    assign bus.dma_d_out = data_buf;

    always_comb begin
        bus.dma_a = '0;
        case (state)
            DMA_HALT, DMA_ALIGN: bus.dma_a = bus.cpu_a;
            DMA_READ:            bus.dma_a = {page, idx};
            DMA_WRITE:           bus.dma_a = OAM_DATA_ADDR;
            default:             bus.dma_a = '0;
        endcase
    end

endmodule

// File: tb/tb_oam_dma.sv
// Self-checking bench for oam_dma: decode table, hand-written corner sequences and
// randomised transfers checked against a byte-level copy model with a parity-based alignment rule.
module tb_oam_dma;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    oam_dma_if bus();
    oam_dma dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [7:0] mem [0:65535];
    assign bus.dma_d_in = mem[bus.dma_a];

    int checks = 0;
    int errors = 0;
    logic [15:0] idle_a = 16'h8000;

    // Non-reset edges since the last reset edge; its parity is the expected "odd" flop.
    int unsigned edges = 0;
    always @(posedge clk) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    typedef struct {
        logic [15:0] a;
        logic [7:0]  d;
        logic        rw;
        logic        exp_halt;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_idle();
        bus.cpu_a  = idle_a;
        bus.cpu_d  = 8'($urandom);
        bus.cpu_rw = 1'b1;
    endtask

    task automatic drive_trigger(input logic [7:0] page);
        bus.cpu_a  = 16'h4014;
        bus.cpu_d  = page;
        bus.cpu_rw = 1'b0;
    endtask

    // mode 0: plain transfer; 1: retrigger with another page mid-transfer;
    // 2: trigger held on the edge that ends the last WRITE.
    task automatic run_transfer(input logic [7:0] page, input int mode);
        int halt_cyc = 0, nwr = 0, wr_bad = 0, rd_bad = 0, busy_bad = 0, cyc = 0;
        bit exp_align, done = 0, first = 1;
        logic [15:0] prev_a = 16'h0;
        logic [15:0] last_rd = 16'h0;
        idle_a = {1'b1, 15'($urandom)};
        drive_trigger(page);
        @(posedge clk);
        #1;
        exp_align = edges[0];
        set_idle();
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (first) begin
                check("halt_rises_after_trigger", bus.cpu_halt, 1);
                first = 0;
            end
            if (bus.dma_busy !== bus.cpu_halt) busy_bad++;
            if (bus.cpu_halt) begin
                if (halt_cyc == 0) begin
                    check("halt_cycle_addr_passthru", bus.dma_a, bus.cpu_a);
                    check("halt_cycle_rw", bus.dma_rw, 1);
                end
                halt_cyc++;
                if (bus.dma_rw == 1'b0) begin
                    if (bus.dma_a !== 16'h2004 || bus.dma_d_out !== mem[{page, nwr[7:0]}]) wr_bad++;
                    if (prev_a !== {page, nwr[7:0]}) rd_bad++;
                    last_rd = prev_a;
                    nwr++;
                    if (mode == 2 && nwr == 256) drive_trigger(~page);
                end
                prev_a = bus.dma_a;
                if (mode == 1 && halt_cyc == 77) drive_trigger(~page);
                if (mode == 1 && halt_cyc == 79) set_idle();
            end else if (halt_cyc > 0) begin
                done = 1;
            end
        end
        set_idle();
        check("transfer_completes", done, 1);
        check("halt_cycles", halt_cyc, 513 + exp_align);
        check("write_count", nwr, 256);
        check("write_data_bad", wr_bad, 0);
        check("read_addr_bad", rd_bad, 0);
        check("last_read_addr", last_rd, {page, 8'hFF});
        check("busy_alias_bad", busy_bad, 0);
        if (mode == 2) begin
            repeat (3) @(negedge clk);
            check("no_trigger_on_final_edge", bus.cpu_halt, 0);
        end
    endtask

    // Move to a point where the next posedge leaves edge parity == want_align.
    task automatic align_parity(input bit want_align);
        @(negedge clk);
        if (((edges + 1) & 1) != want_align) @(negedge clk);
    endtask

    vec_t vecs[7];

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
        set_idle();

        // Reset held for two clocks
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("reset_cpu_halt", bus.cpu_halt, 0);
        check("reset_dma_busy", bus.dma_busy, 0);
        check("reset_dma_rw", bus.dma_rw, 1);
        check("reset_dma_a", bus.dma_a, 0);
        check("reset_dma_d_out", bus.dma_d_out, 0);

        // Trigger decode table
        vecs[0] = '{16'h4015, 8'h02, 1'b0, 1'b0};
        vecs[1] = '{16'h2004, 8'h02, 1'b0, 1'b0};
        vecs[2] = '{16'h4014, 8'h02, 1'b1, 1'b0};
        vecs[3] = '{16'h4013, 8'h02, 1'b0, 1'b0};
        vecs[4] = '{16'hC014, 8'h02, 1'b0, 1'b0};
        vecs[5] = '{16'h4014, 8'h07, 1'b0, 1'b1};
        vecs[6] = '{16'h0014, 8'h02, 1'b0, 1'b0};
        for (int v = 0; v < 7; v++) begin
            bus.cpu_a  = vecs[v].a;
            bus.cpu_d  = vecs[v].d;
            bus.cpu_rw = vecs[v].rw;
            @(negedge clk);
            set_idle();
            check($sformatf("decode_%0d_halt", v), bus.cpu_halt, vecs[v].exp_halt);
            check($sformatf("decode_%0d_rw", v), bus.dma_rw, 1);
            if (vecs[v].exp_halt) begin
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                check($sformatf("decode_%0d_abort", v), bus.cpu_halt, 0);
            end
        end

        // Basic transfer, no ALIGN then with ALIGN
        align_parity(1'b0);
        run_transfer(8'h02, 0);
        align_parity(1'b1);
        run_transfer(8'h02, 0);

        // Last page: must stop at $FFFF without touching $0000
        run_transfer(8'hFF, 0);

        // Reset while reading idx 100, then restart from idx 0
        begin
            bit found = 0;
            drive_trigger(8'h03);
            @(negedge clk);
            set_idle();
            for (int c = 0; c < 600 && !found; c++) begin
                if (bus.cpu_halt && bus.dma_rw && bus.dma_a == 16'h0364) found = 1;
                else @(negedge clk);
            end
            check("reached_idx_100", found, 1);
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            check("midreset_cpu_halt", bus.cpu_halt, 0);
            check("midreset_dma_a", bus.dma_a, 0);
            check("midreset_dma_d_out", bus.dma_d_out, 0);
            @(negedge clk);
            check("midreset_stays_idle", bus.cpu_halt, 0);
            run_transfer(8'h03, 0);
        end

        // Retrigger during transfer and trigger on the final edge
        run_transfer(8'h02, 1);
        run_transfer(8'h41, 2);

        // Randomised transfers
        for (int t = 0; t < 6; t++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            run_transfer(8'($urandom), $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
